// File: rtl/probe_rle_encoder_if.sv
// Write side of the FX2 slave FIFO (FIFO4) as driven by the probe RLE encoder.
// The encoder is the master; the FIFO (or a bench) is the slave.
interface probe_rle_encoder_if;
    logic       fifo_ready;
    logic       fifo_wr;
    logic [7:0] fifo_data;

    modport master (input fifo_ready, output fifo_wr, output fifo_data);
    modport slave  (output fifo_ready, input fifo_wr, input fifo_data);
endinterface

// File: rtl/probe_rle_encoder.sv
// Run-length encoder for the logic-analyzer probe byte: emits {value, run} byte pairs
// into FIFO4 through a small circular pair buffer, marking lost pairs with {00,00}.
module probe_rle_encoder #(
    parameter int ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 sample,
    probe_rle_encoder_if.master        fifo,
    output logic                       overflow
);
    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        PH_VALUE = 1'b0,
        PH_RUN   = 1'b1
    } phase_t;

    logic [7:0]        cur_val;
    logic [7:0]        run;
    logic              valid;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    phase_t            phase;
    logic              gap_pending;
    logic [15:0]       head;
    logic [15:0]       push_pair;
    logic              pair_done;
    logic              space;
    logic              push;
    logic              pop;
    logic              drop;

    assign head           = mem[rd_ptr];
    assign fifo.fifo_wr   = (count != '0) && fifo.fifo_ready;
    assign fifo.fifo_data = (phase == PH_RUN) ? head[7:0] : head[15:8];

    // A pop on the same edge frees a slot, so a full buffer can still accept the push.
    always_comb begin
        // NOTE: every signal gets a default before any condition so no path leaves it
        // unassigned, which would otherwise infer a latch.
        pair_done = 1'b0;
        pop       = 1'b0;
        space     = 1'b0;
        push      = 1'b0;
        drop      = 1'b0;
        push_pair = {cur_val, run};
        if (valid && !((sample == cur_val) && (run != 8'hFF)))
            pair_done = 1'b1;
        if (fifo.fifo_wr && (phase == PH_RUN))
            pop = 1'b1;
        space = (count != FULL) || pop;
        push  = pair_done && space;
        drop  = pair_done && !space;
        if (gap_pending)
            push_pair = 16'h0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            cur_val <= 8'h00;
            run     <= 8'h00;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b1;
            if (!valid || pair_done) begin
                cur_val <= sample;
                run     <= 8'd1;
            end else begin
                run <= run + 8'd1;
            end
        end
    end

    // NOTE: the buffer is reset deliberately: the idle output byte must read a cleared
    // entry 0, and the array is small enough for flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 16'h0000;
        end else if (push) begin
            mem[wr_ptr] <= push_pair;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
        end
    end

    // The first pair accepted after a drop is replaced by the loss marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= PH_VALUE;
            gap_pending <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (fifo.fifo_wr)
                phase <= (phase == PH_VALUE) ? PH_RUN : PH_VALUE;
            if (drop) begin
                gap_pending <= 1'b1;
                overflow    <= 1'b1;
            end else if (push) begin
                gap_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_probe_rle_encoder.sv
// Self-checking bench for probe_rle_encoder: queue-based reference model feeds an
// expected-byte scoreboard that an independent monitor drains on every FIFO write.
module tb_probe_rle_encoder;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic       clk;
    logic       reset;
    logic [7:0] sample;
    logic       overflow;

    probe_rle_encoder_if fif ();

    probe_rle_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .sample   (sample),
        .fifo     (fif),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: buffered pairs, output byte phase, loss flags, run tracker.
    logic [15:0] m_q [$];
    logic [7:0]  exp_q [$];
    bit          m_ph;
    bit          m_gap;
    bit          m_ovf;
    bit          m_valid;
    logic [7:0]  m_cur;
    int          m_run;
    logic        last_wr;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_ph    = 1'b0;
        m_gap   = 1'b0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
        m_cur   = 8'h00;
        m_run   = 0;
    endtask

    // One clock edge of the behaviour: output byte, run tracking, then buffer bookkeeping.
    task automatic model_step(input logic [7:0] s, input logic r);
        bit          wr;
        bit          pop;
        logic [15:0] pr;
        wr  = (m_q.size() != 0) && r;
        pop = wr && m_ph;
        if (!m_valid) begin
            m_valid = 1'b1;
            m_cur   = s;
            m_run   = 1;
        end else if (s == m_cur && m_run < 255) begin
            m_run++;
        end else begin
            pr = {m_cur, 8'(m_run)};
            if (m_q.size() < DEPTH || pop) begin
                if (m_gap) begin
                    pr    = 16'h0000;
                    m_gap = 1'b0;
                end
                m_q.push_back(pr);
                exp_q.push_back(pr[15:8]);
                exp_q.push_back(pr[7:0]);
            end else begin
                m_gap = 1'b1;
                m_ovf = 1'b1;
            end
            m_cur = s;
            m_run = 1;
        end
        if (pop)
            void'(m_q.pop_front());
        if (wr)
            m_ph = !m_ph;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [7:0] s, input logic r);
        sample         = s;
        fif.fifo_ready = r;
        #1;
        last_wr = fif.fifo_wr;
        check("fifo_wr", fif.fifo_wr, (m_q.size() != 0) && r);
        check("overflow", overflow, m_ovf);
        model_step(s, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_fifo_wr", fif.fifo_wr, 1'b0);
        check("reset_fifo_data", fif.fifo_data, 8'h00);
        check("reset_overflow", overflow, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every byte the DUT writes must be the oldest expected byte.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && fif.fifo_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("fifo_data", fif.fifo_data, exp_b);
                end
            end
        end
    end

    initial begin
        int          first_wr;
        int          n_wr;
        logic [7:0]  v;
        int          len;
        int          pct;
        reset          = 1'b1;
        sample         = 8'h00;
        fif.fifo_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Constant run: first byte one clock after the 256th edge, then every 255 clocks.
        first_wr = 0;
        n_wr     = 0;
        for (int k = 1; k <= 600; k++) begin
            step(8'hA5, 1'b1);
            if (last_wr) begin
                n_wr++;
                if (first_wr == 0)
                    first_wr = k;
            end
        end
        check("const_first_write_step", first_wr, 257);
        check("const_write_count", n_wr, 4);

        // Short runs 01x3, 02x5, then 03 held.
        do_reset();
        repeat (3) step(8'h01, 1'b1);
        repeat (5) step(8'h02, 1'b1);
        repeat (20) step(8'h03, 1'b1);

        // Backpressure: four pairs complete while the FIFO is not ready.
        do_reset();
        repeat (2) step(8'h10, 1'b0);
        repeat (3) step(8'h11, 1'b0);
        repeat (1) step(8'h12, 1'b0);
        repeat (2) step(8'h13, 1'b0);
        repeat (4) step(8'h14, 1'b0);
        n_wr = 0;
        for (int k = 0; k < 8; k++) begin
            step(8'h14, 1'b1);
            if (last_wr)
                n_wr++;
        end
        check("backpressure_burst", n_wr, 8);
        repeat (10) step(8'h14, 1'b1);

        // Overflow: ten single-clock values into a four-pair buffer, then drain.
        do_reset();
        for (int k = 0; k < 10; k++)
            step(8'(k), 1'b0);
        check("overflow_set", overflow, 1'b1);
        repeat (5) step(8'h09, 1'b0);
        repeat (12) step(8'h09, 1'b1);
        repeat (6) step(8'h20, 1'b1);
        repeat (12) step(8'h21, 1'b1);

        // Reset right after a value byte: nothing stale may follow.
        do_reset();
        for (int k = 0; k < 40 && !m_ph; k++)
            step(8'(8'h40 + k), 1'b1);
        check("midpair_phase_reached", m_ph, 1'b1);
        do_reset();
        repeat (4) step(8'h55, 1'b1);
        repeat (10) step(8'h66, 1'b1);

        // Randomized segments: mixed run lengths, FIFO stalls and occasional reset.
        for (int seg = 0; seg < 300; seg++) begin
            v   = 8'($urandom_range(0, 255));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 4);
            pct = $urandom_range(0, 100);
            for (int k = 0; k < len; k++)
                step(v, 1'($urandom_range(0, 99) < pct));
            if ($urandom_range(0, 99) == 0)
                do_reset();
        end

        repeat (30) step(v, 1'b1);
        #3;
        check("drain_remaining", exp_q.size(), 2 * m_q.size() - int'(m_ph));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
